// File: rtl/mine_generator_if.sv
// Request/result bundle between the game control FSM and the mine generator.
// CELLS and IDX_W must match the generator's GRID_W*GRID_H and $clog2 of that.
interface mine_generator_if #(
  parameter int CELLS = 256,
  parameter int IDX_W = 8
);
  logic             start;
  logic [IDX_W-1:0] safe_idx;
  logic             busy;
  logic             done;
  logic [CELLS-1:0] mine_map;
  logic [IDX_W:0]   mine_cnt;

  modport master (output start, safe_idx, input busy, done, mine_map, mine_cnt);
  modport slave  (input start, safe_idx, output busy, done, mine_map, mine_cnt);
endinterface

// File: rtl/mine_generator.sv
// Places NUM_MINES distinct mines on a GRID_W x GRID_H board from a free-running LFSR,
// never mining the latched safe cell. Result is a flat bitmap held until the next start.
module mine_generator #(
  parameter int          GRID_W    = 16,
  parameter int          GRID_H    = 16,
  parameter int          NUM_MINES = 40,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic            clk,
  input logic            reset,
  mine_generator_if.slave gen
);
  localparam int             CELLS    = GRID_W * GRID_H;
  localparam int             IDX_W    = $clog2(CELLS);
  localparam logic [15:0]    SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [IDX_W:0] CELLS_W  = (IDX_W+1)'(CELLS);
  localparam logic [IDX_W:0] NUM_W    = (IDX_W+1)'(NUM_MINES);

  typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CELLS-1:0] mine_map_q, mine_map_d;
  logic [IDX_W:0]   mine_cnt_q, mine_cnt_d;
  logic [IDX_W-1:0] safe_q, safe_d;

  logic [IDX_W-1:0] cand;
  logic [IDX_W:0]   cnt_inc;
  logic             in_range, cand_ok;

  assign cand     = lfsr_q[IDX_W-1:0];
  assign cnt_inc  = mine_cnt_q + (IDX_W+1)'(1);
  assign in_range = ({1'b0, cand} < CELLS_W);
  // in_range guards the map lookup so non-power-of-two boards never index past the map
  assign cand_ok  = in_range && !mine_map_q[cand] && (cand != safe_q);

  always_comb begin
    state_d    = state_q;
    mine_map_d = mine_map_q;
    mine_cnt_d = mine_cnt_q;
    safe_d     = safe_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    case (state_q)
      IDLE, DONE: begin
        if (gen.start) begin
          safe_d  = gen.safe_idx;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        mine_map_d = '0;
        mine_cnt_d = '0;
        state_d    = PLACE;
      end
      PLACE: begin
        if (cand_ok) begin
          mine_map_d[cand] = 1'b1;
          mine_cnt_d       = cnt_inc;
          if (cnt_inc == NUM_W) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED_EFF;
      mine_map_q <= '0;
      mine_cnt_q <= '0;
      safe_q     <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      mine_map_q <= mine_map_d;
      mine_cnt_q <= mine_cnt_d;
      safe_q     <= safe_d;
    end
  end

  assign gen.busy     = (state_q == CLEAR) || (state_q == PLACE);
  assign gen.done     = (state_q == DONE);
  assign gen.mine_map = mine_map_q;
  assign gen.mine_cnt = mine_cnt_q;
endmodule
